// File: rtl/ctlr_pkg.sv
// Shared definitions for the controller scanner.
//   - CTLR_ADDR_P1 / CTLR_ADDR_P2: CPU addresses of the two controller registers.
//   - scan_state_e: states of the serial scan sequencer.
//   - cnt_w(): counter width for a count of n cycles (never below 1 bit).
package ctlr_pkg;

  localparam logic [15:0] CTLR_ADDR_P1 = 16'h4016;
  localparam logic [15:0] CTLR_ADDR_P2 = 16'h4017;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StPulseLo,
    StPulseHi,
    StCommit,
    StWait
  } scan_state_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/ctlr_port_shift.sv
// Per-port button storage.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   en_i            : cycle enable; nothing changes while low
//   sample_i        : write sample_bit_i into shadow bit sample_idx_i
//   commit_i        : copy shadow into snapshot
//   reload_i        : load CPU shift register (from shadow when commit_i coincides)
//   shift_i         : shift CPU register one place, filling with 1
//   strobe_i        : CPU strobe level; while high the head reads snapshot bit 0
//   head_o          : bit presented to the CPU on the next read
module ctlr_port_shift
  import ctlr_pkg::*;
#(
  parameter int unsigned BITS = 8,
  parameter int unsigned IdxW = cnt_w(BITS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            sample_i,
  input  logic [IdxW-1:0] sample_idx_i,
  input  logic            sample_bit_i,
  input  logic            commit_i,
  input  logic            reload_i,
  input  logic            shift_i,
  input  logic            strobe_i,
  output logic            head_o
);

  logic [BITS-1:0] shadow_q, shadow_d;
  logic [BITS-1:0] snap_q, snap_d;
  logic [BITS-1:0] sr_q, sr_d;

  always_comb begin
    shadow_d = shadow_q;
    snap_d   = snap_q;
    sr_d     = sr_q;
    if (sample_i) shadow_d[sample_idx_i] = sample_bit_i;
    if (commit_i) snap_d = shadow_q;
    // A reload on the commit cycle must see the freshly committed data.
    if (reload_i)     sr_d = commit_i ? shadow_q : snap_q;
    else if (shift_i) sr_d = {1'b1, sr_q[BITS-1:1]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      snap_q   <= '0;
      sr_q     <= '0;
    end else if (en_i) begin
      shadow_q <= shadow_d;
      snap_q   <= snap_d;
      sr_q     <= sr_d;
    end
  end

  // The register only catches up with a newly raised strobe one cycle later.
  assign head_o = strobe_i ? snap_q[0] : sr_q[0];

endmodule

// File: rtl/ctlr_scanner.sv
// Serial game-controller scanner with a CPU-visible latch/shift register interface.
//   clock, reset_n   : system clock, asynchronous active-low reset
//   clock_en         : CPU cycle enable; all state advances only when high
//   addr, r_en       : CPU bus address, 1 = read / 0 = write
//   w_data           : CPU write data (bit 0 is the strobe)
//   ctlr_data        : serial button data per port, active-low
//   ctlr_pulse       : per-port shift clock, idle high
//   ctlr_latch       : shared latch strobe, idle low
//   button_data_rd   : registered CPU read data
//   scan_valid       : high once a full scan has committed
module ctlr_scanner
  import ctlr_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned BITS        = 8,
  parameter int unsigned LATCH_CYC   = 12,
  parameter int unsigned PULSE_CYC   = 6,
  parameter int unsigned SCAN_PERIOD = 29780
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clock_en,
  input  logic [15:0]          addr,
  input  logic                 r_en,
  input  logic [7:0]           w_data,
  input  logic [NUM_PORTS-1:0] ctlr_data,
  output logic [NUM_PORTS-1:0] ctlr_pulse,
  output logic                 ctlr_latch,
  output logic [7:0]           button_data_rd,
  output logic                 scan_valid
);

  localparam int unsigned LatW = cnt_w(LATCH_CYC);
  localparam int unsigned PulW = cnt_w(PULSE_CYC);
  localparam int unsigned BitW = cnt_w(BITS);
  localparam int unsigned PerW = cnt_w(SCAN_PERIOD);

  if (SCAN_PERIOD < LATCH_CYC + 2 * PULSE_CYC * (BITS - 1) + 2) begin : g_bad_period
    $error("SCAN_PERIOD too short for one complete scan");
  end
  if (NUM_PORTS < 1 || NUM_PORTS > 4) begin : g_bad_ports
    $error("NUM_PORTS must be 1..4");
  end
  if (BITS != 8 && BITS != 16) begin : g_bad_bits
    $error("BITS must be 8 or 16");
  end

  // Scan sequencer
  scan_state_e     state_q, state_d;
  logic [LatW-1:0] lat_cnt_q, lat_cnt_d;
  logic [PulW-1:0] pul_cnt_q, pul_cnt_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [PerW-1:0] per_q, per_d;
  logic            valid_q, valid_d;
  logic            sample, commit;
  logic [BitW-1:0] sample_idx;

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    pul_cnt_d  = pul_cnt_q;
    bit_d      = bit_q;
    per_d      = per_q + 1'b1;
    valid_d    = valid_q;
    sample     = 1'b0;
    sample_idx = bit_q;
    commit     = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d   = StLatch;
        lat_cnt_d = '0;
        per_d     = '0;
      end
      StLatch: begin
        if (lat_cnt_q == LatW'(LATCH_CYC - 1)) begin
          state_d    = StPulseLo;
          pul_cnt_d  = '0;
          sample     = 1'b1;
          sample_idx = '0;
          bit_d      = BitW'(1);
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      StPulseLo: begin
        if (pul_cnt_q == PulW'(PULSE_CYC - 1)) begin
          state_d   = StPulseHi;
          pul_cnt_d = '0;
          sample    = 1'b1;
        end else begin
          pul_cnt_d = pul_cnt_q + 1'b1;
        end
      end
      StPulseHi: begin
        if (pul_cnt_q == PulW'(PULSE_CYC - 1)) begin
          pul_cnt_d = '0;
          if (bit_q == BitW'(BITS - 1)) begin
            state_d = StCommit;
          end else begin
            state_d = StPulseLo;
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          pul_cnt_d = pul_cnt_q + 1'b1;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        valid_d = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        // per_q counts enabled cycles since the current scan entered LATCH.
        if (per_q == PerW'(SCAN_PERIOD - 1)) begin
          state_d   = StLatch;
          lat_cnt_d = '0;
          per_d     = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // CPU interface
  logic                 strobe_q, strobe_d;
  logic [7:0]           rd_q, rd_d;
  logic                 wr_strobe, rd_hit;
  logic [NUM_PORTS-1:0] head;
  logic [3:0]           head_pad;
  logic                 unused_wdata;

  assign unused_wdata = ^w_data[7:1];
  assign wr_strobe    = clock_en && !r_en && (addr == CTLR_ADDR_P1);
  assign rd_hit       = clock_en && r_en && ((addr == CTLR_ADDR_P1) || (addr == CTLR_ADDR_P2));
  assign head_pad     = 4'(head);

  always_comb begin
    strobe_d = wr_strobe ? w_data[0] : strobe_q;
    rd_d     = rd_q;
    // Even ports sit on 4016, odd ports on 4017; port k drives bit k/2.
    if (rd_hit) rd_d = addr[0] ? {6'b0, head_pad[3], head_pad[1]}
                               : {6'b0, head_pad[2], head_pad[0]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      lat_cnt_q <= '0;
      pul_cnt_q <= '0;
      bit_q     <= '0;
      per_q     <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      rd_q      <= '0;
    end else if (clock_en) begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      pul_cnt_q <= pul_cnt_d;
      bit_q     <= bit_d;
      per_q     <= per_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      rd_q      <= rd_d;
    end
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    localparam logic PortOdd = 1'(k % 2);
    ctlr_port_shift #(
      .BITS (BITS)
    ) u_port (
      .clk_i        (clock),
      .rst_ni       (reset_n),
      .en_i         (clock_en),
      .sample_i     (sample),
      .sample_idx_i (sample_idx),
      .sample_bit_i (~ctlr_data[k]),
      .commit_i     (commit),
      .reload_i     (strobe_q),
      .shift_i      (rd_hit && (addr[0] == PortOdd)),
      .strobe_i     (strobe_q),
      .head_o       (head[k])
    );
  end

  assign ctlr_latch     = (state_q == StLatch);
  assign ctlr_pulse     = (state_q == StPulseLo) ? '0 : '1;
  assign button_data_rd = rd_q;
  assign scan_valid     = valid_q;

endmodule

// File: tb/tb_ctlr_scanner.sv
module tb_ctlr_scanner;

  localparam logic [15:0] P1 = ctlr_pkg::CTLR_ADDR_P1;
  localparam logic [15:0] P2 = ctlr_pkg::CTLR_ADDR_P2;

  logic        clock;
  logic        reset_n;
  logic        clock_en;
  logic [15:0] addr;
  logic        r_en;
  logic [7:0]  w_data;

  logic [1:0]  data1, pulse1;
  logic        latch1, valid1;
  logic [7:0]  rd1;
  logic [3:0]  data2, pulse2;
  logic        latch2, valid2;
  logic [7:0]  rd2;

  ctlr_scanner u_dut1 (
    .clock          (clock),
    .reset_n        (reset_n),
    .clock_en       (clock_en),
    .addr           (addr),
    .r_en           (r_en),
    .w_data         (w_data),
    .ctlr_data      (data1),
    .ctlr_pulse     (pulse1),
    .ctlr_latch     (latch1),
    .button_data_rd (rd1),
    .scan_valid     (valid1)
  );

  ctlr_scanner #(
    .NUM_PORTS (4),
    .BITS      (16)
  ) u_dut2 (
    .clock          (clock),
    .reset_n        (reset_n),
    .clock_en       (clock_en),
    .addr           (addr),
    .r_en           (r_en),
    .w_data         (w_data),
    .ctlr_data      (data2),
    .ctlr_pulse     (pulse2),
    .ctlr_latch     (latch2),
    .button_data_rd (rd2),
    .scan_valid     (valid2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Controller models: reload on latch, advance one bit per falling pulse edge.
  logic [7:0] btn0;
  int         idx1, idx2;
  logic       prev1, prev2;

  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx1  <= 0;
      idx2  <= 0;
      prev1 <= 1'b1;
      prev2 <= 1'b1;
    end else begin
      if (latch1) idx1 <= 0;
      else if (prev1 && !pulse1[0]) idx1 <= idx1 + 1;
      if (latch2) idx2 <= 0;
      else if (prev2 && !pulse2[0]) idx2 <= idx2 + 1;
      prev1 <= pulse1[0];
      prev2 <= pulse2[0];
    end
  end

  assign data1 = {1'b1, (idx1 < 8) ? ~btn0[idx1[2:0]] : 1'b1};
  assign data2 = {(idx2 != 15), 3'b111};

  int en_cyc = 0;
  always @(posedge clock) if (reset_n && clock_en) en_cyc <= en_cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle, entered and left on a falling clock edge.
  task automatic bus_op(input bit is_rd, input bit en, input logic [15:0] a,
                        input logic [7:0] wd);
    addr     = a;
    r_en     = is_rd;
    w_data   = wd;
    clock_en = en;
    @(negedge clock);
    addr     = 16'h0000;
    r_en     = 1'b1;
    w_data   = 8'h00;
    clock_en = 1'b1;
  endtask

  typedef struct {
    bit          is_rd;
    bit          en;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  exp1;
    logic [7:0]  exp2;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, logic [15:0] a, logic [7:0] wd,
                              logic [7:0] e1, logic [7:0] e2);
    vec_t v;
    v.is_rd = r; v.en = e; v.a = a; v.wd = wd; v.exp1 = e1; v.exp2 = e2;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int lat_cnt, lo, hi, t0;
    bit ok, bad;

    // dut1 port0 = 0x09 (A + Start), port1 idle.
    // dut2 port3 = bit 15 only, ports 0..2 idle.
    tbl.push_back(mk(0, 1, P1, 8'h01, 0, 0));
    tbl.push_back(mk(0, 1, P1, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, P1, 0, 8'h01, 8'h00));
    tbl.push_back(mk(1, 1, P1, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 1, P1, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 0, P1, 0, 8'h00, 8'h00));  // disabled: no update, no shift
    tbl.push_back(mk(1, 1, P1, 0, 8'h01, 8'h00));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, P1, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 1, P1, 0, 8'h01, 8'h00));  // 9th read: exhausted
    tbl.push_back(mk(0, 1, P1, 8'h01, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 1, P1, 0, 8'h01, 8'h00));
    tbl.push_back(mk(0, 1, P1, 8'h00, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 1, P2, 0, 8'h00, 8'h00));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(1, 1, P2, 0, 8'h01, 8'h00));
    tbl.push_back(mk(1, 1, P2, 0, 8'h01, 8'h02));  // 16th read of dut2
    tbl.push_back(mk(1, 1, P2, 0, 8'h01, 8'h03));
    tbl.push_back(mk(1, 1, P1, 0, 8'h01, 8'h00));
    tbl.push_back(mk(1, 1, P1, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 1, P2, 8'h01, 0, 0));      // write to 4017 leaves strobe alone
    tbl.push_back(mk(1, 1, P1, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 1, P1, 0, 8'h01, 8'h00));

    reset_n  = 1'b0;
    clock_en = 1'b1;
    addr     = 16'h0000;
    r_en     = 1'b1;
    w_data   = 8'h00;
    btn0     = 8'h09;
    repeat (3) @(negedge clock);

    check("reset latch1", latch1, 1'b0);
    check("reset pulse1", pulse1, 2'b11);
    check("reset rd1", rd1, 8'h00);
    check("reset valid1", valid1, 1'b0);
    check("reset latch2", latch2, 1'b0);
    check("reset pulse2", pulse2, 4'hf);
    check("reset rd2", rd2, 8'h00);
    check("reset valid2", valid2, 1'b0);

    reset_n = 1'b1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clock);
      if (latch1) ok = 1;
    end
    check("first latch seen", ok, 1'b1);
    check("pulse idle high in latch", pulse1, 2'b11);
    t0 = en_cyc;

    // Latch width in enabled cycles, with a 10-cycle clock_en stall inside it.
    lat_cnt = 0;
    for (int i = 0; i < 200 && latch1; i++) begin
      if (i == 5) clock_en = 1'b0;
      if (i == 15) clock_en = 1'b1;
      if (clock_en) lat_cnt++;
      @(negedge clock);
    end
    clock_en = 1'b1;
    check("latch enabled cycles", lat_cnt, 12);

    for (int p = 0; p < 7; p++) begin
      lo = 0;
      while (pulse1 == 2'b00 && lo < 50) begin lo++; @(negedge clock); end
      check($sformatf("pulse %0d low cycles", p), lo, 6);
      hi = 0;
      if (p < 6) begin
        while (pulse1 == 2'b11 && !latch1 && hi < 50) begin hi++; @(negedge clock); end
        check($sformatf("pulse %0d high cycles", p), hi, 6);
      end else begin
        // Last high phase is followed by the single COMMIT cycle.
        while (!valid1 && hi < 50) begin hi++; @(negedge clock); end
        check("last pulse high + commit", hi, 7);
      end
    end
    check("valid1 after first scan", valid1, 1'b1);

    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (valid2) ok = 1;
      else @(negedge clock);
    end
    check("valid2 after first scan", ok, 1'b1);

    foreach (tbl[i]) begin
      bus_op(tbl[i].is_rd, tbl[i].en, tbl[i].a, tbl[i].wd);
      if (tbl[i].is_rd) begin
        check($sformatf("vec%0d dut1 rd", i), rd1, tbl[i].exp1);
        check($sformatf("vec%0d dut2 rd", i), rd2, tbl[i].exp2);
      end
    end

    ok = 0;
    for (int i = 0; i < 40000 && !ok; i++) begin
      @(negedge clock);
      if (latch1) ok = 1;
    end
    check("second latch seen", ok, 1'b1);
    check("scan period", en_cyc - t0, 29780);

    // Reset in the middle of PULSE_LO of scan 2.
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if (!latch1) ok = 1;
    end
    repeat (2) @(negedge clock);
    check("in pulse_lo before reset", pulse1, 2'b00);
    check("rd1 nonzero before reset", rd1, 8'h01);
    reset_n = 1'b0;
    #1;
    check("mid-scan reset latch1", latch1, 1'b0);
    check("mid-scan reset pulse1", pulse1, 2'b11);
    check("mid-scan reset rd1", rd1, 8'h00);
    check("mid-scan reset valid1", valid1, 1'b0);
    btn0 = 8'h80;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clock);
      if (latch1) ok = 1;
    end
    check("latch after reset release", ok, 1'b1);
    // Cycle 0 of the new scan: raise the strobe, then read a cleared snapshot.
    bus_op(1'b0, 1'b1, P1, 8'h01);
    bus_op(1'b1, 1'b1, P1, 8'h00);
    check("snapshot cleared by reset", rd1, 8'h00);
    bad = 0;
    for (int i = 2; i < 96; i++) begin
      if (valid1) bad = 1;
      @(negedge clock);
    end
    check("valid1 low before commit", bad, 1'b0);
    check("valid1 low in commit cycle", valid1, 1'b0);
    check("pulse high in commit cycle", pulse1, 2'b11);
    bus_op(1'b0, 1'b1, P1, 8'h00);  // strobe falls on the COMMIT cycle
    check("valid1 after commit", valid1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      bus_op(1'b1, 1'b1, P1, 8'h00);
      check($sformatf("commit-reload read %0d", i + 1), rd1, (i >= 7) ? 8'h01 : 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
